// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one single-ported synchronous RAM
module mem_port_arbiter #(
  parameter int READ_LAT = 1,
  parameter int MAX_D_STREAK = 3
) (
  input  logic        clk,
  input  logic        cpu_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [SW-1:0] d_streak;
  logic grant_i, wr, d_req, fetch_win, start;
  assign d_req = d_ren | d_wen;
  assign fetch_win = i_req & (~d_req | (d_streak == STREAK_MAX));
  assign start = (state == IDLE) & (d_req | i_req);
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);
  // state register
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: stores skip WAIT, loads/fetches wait out the RAM latency
  always_comb begin
    state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
               state == ISSUE ? (wr ? RESP : WAIT) :
               state == WAIT  ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  // outputs decoded from state so reset drops the strobe immediately
  always_comb begin
    ram_en = state == ISSUE;
    ram_we = (state == ISSUE) & wr;
    i_ack  = (state == RESP) & grant_i;
    d_ack  = (state == RESP) & ~grant_i;
  end
  // arbitration latch, latency counter and read-data capture
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      grant_i   <= 1'b0;
      wr        <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      d_streak  <= '0;
      cnt       <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (start) begin
        grant_i   <= fetch_win;
        wr        <= ~fetch_win & d_wen;
        ram_addr  <= fetch_win ? i_addr : d_addr;
        ram_wdata <= d_wdata;
        d_streak  <= (fetch_win | ~i_req) ? '0 :
                     (d_streak == STREAK_MAX) ? d_streak : d_streak + 1'b1;
      end
      if (state == ISSUE) cnt <= 4'(READ_LAT);
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (grant_i) i_rdata <= ram_rdata;
          else d_rdata <= ram_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of two arbiters, READ_LAT=1 (a_*) and READ_LAT=4 (b_*)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic        a_i_req = 1'b0, a_d_ren = 1'b0, a_d_wen = 1'b0;
  logic [31:0] a_i_addr = '0, a_d_addr = '0, a_d_wdata = '0, a_ram_rdata;
  logic [31:0] a_i_rdata, a_d_rdata, a_ram_addr, a_ram_wdata;
  logic        a_i_ack, a_d_ack, a_ram_en, a_ram_we, a_stall;
  logic        b_i_req = 1'b0, b_d_ren = 1'b0, b_d_wen = 1'b0;
  logic [31:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0, b_ram_rdata;
  logic [31:0] b_i_rdata, b_d_rdata, b_ram_addr, b_ram_wdata;
  logic        b_i_ack, b_d_ack, b_ram_en, b_ram_we, b_stall;
  logic [31:0] pipe_b [4];
  logic [7:0]  seq;
  int          n;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LAT(1), .MAX_D_STREAK(3)) dut_a (
    .clk(clk), .cpu_rst_n(rst_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
    .d_ren(a_d_ren), .d_wen(a_d_wen), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata), .stall(a_stall)
  );

  mem_port_arbiter #(.READ_LAT(4), .MAX_D_STREAK(3)) dut_b (
    .clk(clk), .cpu_rst_n(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_ren(b_d_ren), .d_wen(b_d_wen), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .stall(b_stall)
  );

  function automatic logic [31:0] rom(input logic [31:0] addr);
    return addr == 32'h10 ? 32'h2402_0005 : addr == 32'h80 ? 32'h1234_5678 : addr ^ 32'hA5A5_0000;
  endfunction

  // RAM models: data valid exactly READ_LAT cycles after the sampling edge, zero otherwise
  always @(posedge clk) a_ram_rdata <= (a_ram_en & ~a_ram_we) ? rom(a_ram_addr) : 32'h0;
  always @(posedge clk) begin
    pipe_b[0] <= (b_ram_en & ~b_ram_we) ? rom(b_ram_addr) : 32'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_b[3] <= pipe_b[2];
  end
  assign b_ram_rdata = pipe_b[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset and idle
    tick(); tick();
    chk("rst_a_ram_en", {31'b0, a_ram_en}, 0);
    chk("rst_a_ram_addr", a_ram_addr, 0);
    chk("rst_b_d_rdata", b_d_rdata, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_a", {28'b0, a_ram_en, a_i_ack, a_d_ack, a_stall}, 0);
      chk("idle_b", {28'b0, b_ram_en, b_i_ack, b_d_ack, b_stall}, 0);
    end
    chk("idle_a_rdata", a_i_rdata | a_d_rdata, 0);
    // 2: fetch, READ_LAT=1
    a_i_req = 1'b1; a_i_addr = 32'h10;
    #1 chk("f_c0_stall", {31'b0, a_stall}, 1);
    chk("f_c0_en", {31'b0, a_ram_en}, 0);
    tick();
    chk("f_c1_en_we", {30'b0, a_ram_en, a_ram_we}, 2'b10);
    chk("f_c1_addr", a_ram_addr, 32'h10);
    chk("f_c1_stall", {31'b0, a_stall}, 1);
    tick();
    chk("f_c2_ack_stall", {29'b0, a_ram_en, a_i_ack, a_stall}, 3'b001);
    tick();
    chk("f_c3_ack", {30'b0, a_i_ack, a_d_ack}, 2'b10);
    chk("f_c3_stall", {31'b0, a_stall}, 0);
    chk("f_c3_rdata", a_i_rdata, 32'h2402_0005);
    a_i_req = 1'b0;
    tick();
    // 3: store
    a_d_wen = 1'b1; a_d_addr = 32'h40; a_d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("s_c1_en_we", {30'b0, a_ram_en, a_ram_we}, 2'b11);
    chk("s_c1_addr", a_ram_addr, 32'h40);
    chk("s_c1_wdata", a_ram_wdata, 32'hDEAD_BEEF);
    chk("s_c1_ack", {30'b0, a_i_ack, a_d_ack}, 0);
    tick();
    chk("s_c2_ack", {30'b0, a_i_ack, a_d_ack}, 2'b01);
    chk("s_c2_stall", {31'b0, a_stall}, 0);
    a_d_wen = 1'b0;
    tick();
    // 4: contention, expect D,D,D,I,D,D,D,I
    a_i_req = 1'b1; a_i_addr = 32'h10; a_d_ren = 1'b1; a_d_addr = 32'h80;
    seq = '0; n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick();
      if (a_i_ack | a_d_ack) begin
        seq = {seq[6:0], a_i_ack};
        n++;
        if (a_i_ack) chk("arb_i_rdata", a_i_rdata, 32'h2402_0005);
        else chk("arb_d_rdata", a_d_rdata, 32'h1234_5678);
        if (n == 8) begin a_i_req = 1'b0; a_d_ren = 1'b0; end
      end
    end
    chk("arb_count", n, 8);
    chk("arb_order", {24'b0, seq}, 8'h11);
    tick();
    // 5: load, READ_LAT=4, then fetch keeps d_rdata
    b_d_ren = 1'b1; b_d_addr = 32'h80;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("l4_wait_ack", {31'b0, b_d_ack}, 0);
    end
    tick();
    chk("l4_c6_ack", {30'b0, b_i_ack, b_d_ack}, 2'b01);
    chk("l4_c6_rdata", b_d_rdata, 32'h1234_5678);
    b_d_ren = 1'b0;
    tick();
    b_i_req = 1'b1; b_i_addr = 32'h10;
    for (int c = 1; c <= 6; c++) tick();
    chk("l4_f_ack", {30'b0, b_i_ack, b_d_ack}, 2'b10);
    chk("l4_f_rdata", b_i_rdata, 32'h2402_0005);
    chk("l4_d_hold", b_d_rdata, 32'h1234_5678);
    b_i_req = 1'b0;
    tick();
    // 6: reset during WAIT, then during ISSUE, then clean completion
    b_d_ren = 1'b1; b_d_addr = 32'h44;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1 chk("r_wait_en_ack", {30'b0, b_ram_en, b_d_ack}, 0);
    chk("r_wait_rdata", b_d_rdata, 0);
    chk("r_wait_stall", {31'b0, b_stall}, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("r_hold", {29'b0, b_ram_en, b_i_ack, b_d_ack}, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("r_issue_en", {31'b0, b_ram_en}, 1);
    rst_n = 1'b0;
    #1 chk("r_issue_drop", {31'b0, b_ram_en}, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("r_redo_wait", {31'b0, b_d_ack}, 0);
    end
    tick();
    chk("r_redo_ack", {30'b0, b_i_ack, b_d_ack}, 2'b01);
    chk("r_redo_rdata", b_d_rdata, 32'hA5A5_0044);
    b_d_ren = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous RAM between the instruction-fetch port and the data (load/store) port of the pipelined MIPS core.
- Serialises the two ports' accesses through an issue/wait/respond FSM with a configurable RAM read latency.
- Gives data accesses priority, with a starvation guard for fetch.
- Drives a stall output that the pipeline uses to freeze while any request is outstanding.

Parameters:
- READ_LAT, 1: RAM read latency in cycles, measured from the edge that samples ram_en to valid ram_rdata. Legal range 1..15.
- MAX_D_STREAK, 3: consecutive data grants allowed while i_req waits; after that, fetch is forced.

Ports:
- clk  in  1  main clock, rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word, valid in the i_ack cycle, held until the next i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_ren  in  1  load request, held until d_ack
- d_wen  in  1  store request, held until d_ack
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid in the d_ack cycle, held until the next load d_ack
- d_ack  out  1  one-cycle data completion pulse
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable, qualified by ram_en
- ram_addr  out  32  RAM byte address, registered
- ram_wdata  out  32  RAM write data, registered
- ram_rdata  in  32  RAM read data
- stall  out  1  pipeline freeze request

Behaviour:
- Reset (async, cpu_rst_n=0):
  - Outputs: state=IDLE; ram_en, ram_we, i_ack, d_ack = 0; i_rdata, d_rdata, ram_addr, ram_wdata = 0.
  - Internal: wait counter = 0; d_streak = 0.
  - An access in flight is abandoned with no ack. Reset asserted mid-ISSUE drops ram_en in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If d_ren, d_wen or i_req is set, arbitrate. Latch grant, address, write flag and wdata, then go to ISSUE. Otherwise stay.
- Arbitration:
  - Data wins by default.
  - Fetch wins if i_req=1 and either no data request is present, or d_streak==MAX_D_STREAK.
  - d_streak increments on a data grant made while i_req=1, saturating at MAX_D_STREAK. It clears on any fetch grant, and on a data grant made while i_req=0.
  - d_ren=d_wen=1 is treated as a store.
- ISSUE (1 cycle):
  - ram_en=1; ram_we=1 only for a store; ram_addr/ram_wdata hold the latched values.
  - Store goes to RESP. Load goes to WAIT with counter=READ_LAT.
  - Fetch is always a read.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where counter==1, capture ram_rdata into i_rdata or d_rdata according to the grant, then go to RESP.
- RESP (1 cycle):
  - The ack of the granted port is 1; the other ack is 0. Then go to IDLE.
  - Requests are not sampled in RESP. The requester either deasserts or presents its next request by the following cycle.
- Latency, request first seen in IDLE at cycle 0:
  - Store ack at cycle 2.
  - Read ack at cycle READ_LAT+2.
  - Minimum spacing between grants is one IDLE cycle after RESP.
- stall (combinational) = (i_req & ~i_ack) | ((d_ren|d_wen) & ~d_ack). It is 0 in the ack cycle, which lets the pipeline advance.
- Unrelated request changes during ISSUE/WAIT/RESP are ignored because grant, address and data were latched at arbitration. A requester changing address mid-access is illegal.
- Reads return the full 32-bit word; byte addresses pass through unmodified.

Test Plan:
1. Reset release with idle inputs → ram_en=0, acks=0, stall=0 for 10 cycles; i_rdata=d_rdata=0.
2. READ_LAT=1: i_req=1, i_addr=0x0000_0010, RAM returns 0x2402_0005 → ram_en pulse at cycle 1 with addr 0x10; i_ack and i_rdata=0x2402_0005 at cycle 3; stall=1 in cycles 0–2, 0 at cycle 3.
3. d_wen=1, d_addr=0x0000_0040, d_wdata=0xDEAD_BEEF → cycle 1: ram_en=ram_we=1, addr 0x40, wdata 0xDEADBEEF; d_ack at cycle 2; i_ack never asserted.
4. i_req and d_ren held continuously, MAX_D_STREAK=3 → grant order D,D,D,I,D,D,D,I; no port waits more than 3 foreign grants.
5. READ_LAT=4 load from 0x80 returning 0x1234_5678 → d_ack at cycle 6 with d_rdata=0x1234_5678; d_rdata holds that value through a following fetch.
6. cpu_rst_n pulled low during WAIT of a load → ram_en/acks drop at once, no d_ack issued; after release with d_ren still high, the access restarts from IDLE and completes normally.
